// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: 8051 instruction fetch unit with a DEPTH-entry prefetch queue.
// The unit fetches code bytes over addr_bus/read_en/data_bus. It queues each byte
// together with its code address, and presents the oldest entry to the decoder
// using a valid/ready handshake. A jump flushes the queue and redirects fetching.
// Optional build macro FETCH_WAIT_EN adds the mem_wait port. While mem_wait is
// high, captures are stalled.
module fetch_prefetch_queue #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr_bus,
  output logic              read_en,
  input  logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  input  logic              jump_en,
`ifdef FETCH_WAIT_EN
  input  logic              mem_wait,
`endif
  input  logic [ADDR_W-1:0] jump_addr
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, count_next;
  logic              push, pop, flush, stall, read_en_next;

  // Pointer advance that wraps at DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign ins_valid = (count != '0);
  assign ins_data  = q_data[head];
  assign ins_pc    = q_pc[head];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, queue handshake decisions and next read strobe.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = ins_valid & ins_ready;
    flush      = 1'b0;
    stall      = 1'b0;
`ifdef FETCH_WAIT_EN
    stall      = mem_wait;
`endif
    case (state)
      IDLE:     state_next = FETCH;
      FETCH: begin
        push = read_en & ~stall;
        if (jump_en) begin
          flush      = 1'b1;
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        if (jump_en) flush = 1'b1;
        else         state_next = FETCH;
      end
      default:  state_next = IDLE;
    endcase
    // A jump discards both the capture and the pop at that edge.
    if (flush) begin
      push = 1'b0;
      pop  = 1'b0;
    end
    count_next = count;
    if (flush)              count_next = '0;
    else if (push && !pop)  count_next = count + CNT_W'(1);
    else if (pop && !push)  count_next = count - CNT_W'(1);
    read_en_next = (state_next == FETCH) && (count_next < DEPTH_C);
  end

  // Fetch address, read strobe and queue storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_bus <= PC_RST;
      read_en  <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      read_en <= read_en_next;
      count   <= count_next;
      if (flush) begin
        addr_bus <= jump_addr;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (push) begin
          q_data[tail] <= data_bus;
          q_pc[tail]   <= addr_bus;
          tail         <= ptr_inc(tail);
          addr_bus     <= addr_bus + ADDR_W'(1);
        end
        if (pop) head <= ptr_inc(head);
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with the default parameters: ADDR_W=8, DEPTH=4.
// The code memory model returns addr+8'h10. The mem_wait step runs only when the
// bench is built with FETCH_WAIT_EN.
module tb_fetch_prefetch_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr_bus;
  logic       read_en;
  logic [7:0] data_bus;
  logic [7:0] ins_data;
  logic [7:0] ins_pc;
  logic       ins_valid;
  logic       ins_ready;
  logic       jump_en;
  logic [7:0] jump_addr;
`ifdef FETCH_WAIT_EN
  logic       mem_wait;
`endif

  int checks = 0;
  int failures = 0;

  fetch_prefetch_queue #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .read_en(read_en),
    .data_bus(data_bus), .ins_data(ins_data), .ins_pc(ins_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .jump_en(jump_en),
`ifdef FETCH_WAIT_EN
    .mem_wait(mem_wait),
`endif
    .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;

  // Zero-wait code memory: byte at address a is a+8'h10.
  assign data_bus = addr_bus + 8'h10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_pc;
    reset     = 1'b0;
    ins_ready = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 8'h00;
`ifdef FETCH_WAIT_EN
    mem_wait  = 1'b0;
`endif
    tick();
    tick();
    chk("rst_addr",  addr_bus,  8'h00);
    chk("rst_rden",  read_en,   1'b0);
    chk("rst_valid", ins_valid, 1'b0);
    chk("rst_data",  ins_data,  8'h00);
    chk("rst_pc",    ins_pc,    8'h00);

    // Release reset. Edge 1 moves the FSM out of IDLE, and edge 2 is the first capture.
    reset = 1'b1;
    tick();
    chk("e1_rden",  read_en,   1'b1);
    chk("e1_valid", ins_valid, 1'b0);
    tick();
    chk("e2_valid", ins_valid, 1'b1);
    chk("e2_data",  ins_data,  8'h10);
    chk("e2_pc",    ins_pc,    8'h00);
    chk("e2_addr",  addr_bus,  8'h01);

    // With the decoder stalled, exactly four captures happen (addresses 0 to 3).
    tick(); tick(); tick();
    chk("full_rden", read_en,  1'b0);
    chk("full_addr", addr_bus, 8'h04);
    chk("full_data", ins_data, 8'h10);
    tick();
    chk("hold_rden", read_en,  1'b0);
    chk("hold_addr", addr_bus, 8'h04);

    // One pop, then the queue refills to four entries.
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    chk("pop_data", ins_data, 8'h11);
    chk("pop_pc",   ins_pc,   8'h01);
    chk("pop_rden", read_en,  1'b1);
    tick();
    chk("refill_rden", read_en,  1'b0);
    chk("refill_addr", addr_bus, 8'h05);
    chk("refill_data", ins_data, 8'h11);

    // Streaming at one byte per cycle with the decoder always ready.
    ins_ready = 1'b1;
    exp_pc = 8'h02;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      chk("stream_valid", ins_valid, 1'b1);
      chk("stream_pc",    ins_pc,    exp_pc);
      chk("stream_data",  ins_data,  8'(exp_pc + 8'h10));
      exp_pc = exp_pc + 8'h01;
    end

    // Fill the queue, then jump to 8'h40.
    ins_ready = 1'b0;
    tick();
    chk("prejump_rden",  read_en,   1'b0);
    chk("prejump_valid", ins_valid, 1'b1);
    jump_en   = 1'b1;
    jump_addr = 8'h40;
    tick();
    jump_en = 1'b0;
    chk("jump_valid", ins_valid, 1'b0);
    chk("jump_rden",  read_en,   1'b0);
    chk("jump_addr",  addr_bus,  8'h40);
    tick();
    chk("redir_rden",  read_en,   1'b1);
    chk("redir_valid", ins_valid, 1'b0);
    tick();
    chk("j40_valid", ins_valid, 1'b1);
    chk("j40_pc",    ins_pc,    8'h40);
    chk("j40_data",  ins_data,  8'h50);

    // Jump to 8'h80, then retarget during REDIRECT to 8'hFE.
    jump_en   = 1'b1;
    jump_addr = 8'h80;
    tick();
    jump_addr = 8'hFE;
    tick();
    jump_en = 1'b0;
    chk("retarget_addr",  addr_bus,  8'hFE);
    chk("retarget_rden",  read_en,   1'b0);
    chk("retarget_valid", ins_valid, 1'b0);
    tick();
    chk("retarget_rden2", read_en, 1'b1);

    // The fetch address wraps through 8'hFF to 8'h00 without a stall.
    ins_ready = 1'b1;
    exp_pc = 8'hFE;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk("wrap_valid", ins_valid, 1'b1);
      chk("wrap_pc",    ins_pc,    exp_pc);
      chk("wrap_data",  ins_data,  8'(exp_pc + 8'h10));
      exp_pc = exp_pc + 8'h01;
    end

`ifdef FETCH_WAIT_EN
    // mem_wait holds the fetch at address 2 for three edges.
    reset = 1'b0;
    tick();
    reset     = 1'b1;
    ins_ready = 1'b1;
    tick(); tick(); tick();
    chk("w_pre_addr", addr_bus, 8'h02);
    mem_wait = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("w_addr", addr_bus, 8'h02);
      chk("w_rden", read_en,  1'b1);
    end
    chk("w_valid", ins_valid, 1'b0);
    mem_wait = 1'b0;
    tick();
    chk("w_resume_valid", ins_valid, 1'b1);
    chk("w_resume_data",  ins_data,  8'h12);
    chk("w_resume_pc",    ins_pc,    8'h02);
`endif

    // Assert reset mid-fill (count=3). Outputs must clear with no clock edge.
    reset = 1'b0;
    tick();
    reset     = 1'b1;
    ins_ready = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_rden",  read_en,   1'b1);
    chk("mid_addr",  addr_bus,  8'h03);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rden",  read_en,   1'b0);
    chk("async_valid", ins_valid, 1'b0);
    chk("async_addr",  addr_bus,  8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
